// File: rtl/rr_arbiter8.sv
// Registered 8-way round-robin arbiter feeding the 8-to-3 encoder stage.
// Grants are held until done, owner drop, or HOLD_MAX expiry.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [0:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       rel;
  logic       own_req;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    win_idx = 3'd0;
    cand    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) win_idx = cand;
    end
  end

  assign own_req = req[gnt_idx];
  assign rel     = done || !own_req || (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= 8'd1 << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            state     <= IDLE;
            timeout   <= !done && own_req;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Registered 8-way round-robin arbiter that drives the one-hot request vector into the 8-to-3 encoder stage.
- Samples eight independent request lines and grants exactly one at a time. Presents the grant both as a one-hot vector (encoder input) and as a 3-bit index, so the encoder output can be cross-checked against it.
- Each grant is held until the owner releases it or a hold timeout expires.

Parameters:
- HOLD_MAX, 15, maximum consecutive cycles a grant may be held before forced release; legal range 1..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req  input  8  request lines; bit i = requester i wants the resource
- done  input  1  current owner releases the grant; sampled only in GRANT
- gnt  output  8  registered one-hot grant, or all-zero when no grant is active
- gnt_idx  output  3  binary index of the granted bit; holds its last value when gnt_valid=0
- gnt_valid  output  1  high while gnt is non-zero
- timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX

Behaviour:
- Reset, asynchronous, effective immediately including mid-grant:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - state=IDLE, ptr=0, hold_cnt=0.
- All outputs are registered; there is no combinational path from req or done to any output.
- Invariant: gnt is always all-zero or exactly one-hot, and gnt_valid == |gnt.
- Invariant: when gnt_valid=1, gnt_idx equals the position of the set bit in gnt.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit of req, scanning ptr, ptr+1, ..., ptr+7 modulo 8 (wrap-around).
  - On that edge: load gnt with the one-hot of the winner, gnt_idx=winner, gnt_valid=1, hold_cnt=0, then go to GRANT.
  - Latency: a req set before edge k produces gnt visible after edge k.
- State GRANT, evaluated each edge in this priority order:
  1. done=1 -> release, timeout stays 0.
  2. req[gnt_idx]=0 (owner dropped its request) -> release, timeout stays 0.
  3. hold_cnt==HOLD_MAX-1 -> release and pulse timeout=1 for exactly one cycle.
  4. Otherwise hold_cnt increments and gnt is held.
- On release:
  - gnt=0, gnt_valid=0, gnt_idx keeps the old index.
  - ptr=(gnt_idx+1) mod 8; state=IDLE.
  - The released requester therefore has lowest priority in the next arbitration.
- Dead cycle: there is exactly one IDLE cycle with gnt=0 between any two grants, so back-to-back grants are spaced at least one cycle apart.
- Requests that arrive or change while in GRANT do not affect the grant except through rule 2; they are evaluated at the next IDLE.
- A timeout pulse is never asserted together with a grant. The cycle after the pulse is IDLE with timeout=0.
- done is ignored in IDLE.

Test Plan:
- Reset check: assert rst mid-grant with req=8'b00000100 and gnt active -> gnt, gnt_idx, gnt_valid and timeout go to 0 immediately, before the next edge; after deassert with req=8'b00000100, the first edge gives gnt=8'b00000100 and gnt_idx=3'b010.
- Round-robin rotation: req=8'hFF held, done pulsed one cycle after each grant -> grant order 8'h01, 8'h02, 8'h04, ..., 8'h80, 8'h01. gnt_idx runs 0..7 then wraps to 0, with gnt=0 for one cycle between each grant.
- Wrap-around priority: after releasing idx 6 (ptr=7), req=8'b01000001 -> next grant is idx 0 (8'b00000001), not idx 6.
- Timeout: HOLD_MAX=15, req=8'b00010000 held, done=0 -> gnt=8'b00010000 for exactly 15 cycles, then timeout=1 for 1 cycle with gnt=0. On the following edge, idx 4 is re-granted if it is still the only request.
- Simultaneous events: done=1 on the same edge hold_cnt reaches HOLD_MAX-1 -> release with timeout=0. Owner drops req[2] while others request 8'b00001000 -> release, then after the dead cycle gnt=8'b00001000, gnt_idx=3'b011.
- Encoder consistency: drive gnt into the 8-to-3 encoder under random req/done for 1000 cycles -> whenever gnt_valid=1, encoder out == gnt_idx, and gnt is never multi-hot.
